// File: rtl/lc3_mmio_ctrl_if.sv
// lc3_mmio_ctrl_if: datapath bus, keyboard, display and interrupt signals of the LC-3 MMIO block
interface lc3_mmio_ctrl_if;
  logic [15:0] io_addr;
  logic [15:0] io_wdata;
  logic        io_load;
  logic        io_rd;
  logic [15:0] io_rdata;
  logic        kbd_valid;
  logic [7:0]  kbd_data;
  logic        kbd_ready;
  logic        disp_valid;
  logic [7:0]  disp_data;
  logic        disp_ready;
  logic        IRQ;
  logic [2:0]  INTP;
  logic [7:0]  INTV;
  logic        mcr_run;
  modport master (
    output io_addr, io_wdata, io_load, io_rd, kbd_valid, kbd_data, disp_ready,
    input  io_rdata, kbd_ready, disp_valid, disp_data, IRQ, INTP, INTV, mcr_run
  );
  modport slave (
    input  io_addr, io_wdata, io_load, io_rd, kbd_valid, kbd_data, disp_ready,
    output io_rdata, kbd_ready, disp_valid, disp_data, IRQ, INTP, INTV, mcr_run
  );
endinterface

// File: rtl/lc3_mmio_ctrl.sv
// lc3_mmio_ctrl: LC-3 keyboard/display/MCR registers with keystroke FIFO and interrupt generation
module lc3_mmio_ctrl #(
  parameter int         KBD_DEPTH  = 4,
  parameter int         DISP_DELAY = 8,
  parameter logic [2:0] KBD_PRIO   = 3'd4,
  parameter logic [7:0] KBD_VEC    = 8'h80,
  parameter logic [2:0] DISP_PRIO  = 3'd4,
  parameter logic [7:0] DISP_VEC   = 8'h81
) (
  input logic            clk,
  input logic            rst,
  lc3_mmio_ctrl_if.slave bus
);
  localparam int AW = $clog2(KBD_DEPTH);
  localparam int CW = $clog2(DISP_DELAY + 1);
  typedef enum logic [1:0] {IDLE, SEND, BUSY} state_t;
  state_t        state;
  logic [7:0]    mem [KBD_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic [CW-1:0] dcnt;
  logic          kie, die, nonempty, idle, push, pop, kreq, dreq;
  assign nonempty      = cnt != '0;
  assign idle          = state == IDLE;
  assign bus.kbd_ready = cnt != (AW+1)'(KBD_DEPTH);
  assign push          = bus.kbd_valid && bus.kbd_ready;
  assign pop           = bus.io_rd && bus.io_addr == 16'hFE02 && nonempty;
  assign kreq          = nonempty && kie;
  assign dreq          = idle && die;
  assign bus.io_rdata  = bus.io_addr == 16'hFE00 ? {nonempty, kie, 14'b0} :
                         bus.io_addr == 16'hFE02 ? {8'b0, nonempty ? mem[rptr] : 8'b0} :
                         bus.io_addr == 16'hFE04 ? {idle, die, 14'b0} :
                         bus.io_addr == 16'hFFFE ? {bus.mcr_run, 15'b0} : 16'b0;
  // keystroke storage; occupancy is tracked separately so no reset is needed
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.kbd_data;
  end
  // FIFO pointers, control register bits and the registered interrupt request
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      cnt         <= '0;
      kie         <= 1'b0;
      die         <= 1'b0;
      bus.mcr_run <= 1'b1;
      bus.IRQ     <= 1'b0;
      bus.INTP    <= 3'd0;
      bus.INTV    <= 8'd0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (bus.io_load && bus.io_addr == 16'hFE00) kie <= bus.io_wdata[14];
      if (bus.io_load && bus.io_addr == 16'hFE04) die <= bus.io_wdata[14];
      if (bus.io_load && bus.io_addr == 16'hFFFE) bus.mcr_run <= bus.io_wdata[15];
      bus.IRQ  <= kreq || dreq;
      bus.INTP <= kreq ? KBD_PRIO : dreq ? DISP_PRIO : 3'd0;
      bus.INTV <= kreq ? KBD_VEC : dreq ? DISP_VEC : 8'd0;
    end
  end
  // display handshake: latch on DDR write, offer until accepted, then hold busy for DISP_DELAY cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      dcnt           <= '0;
      bus.disp_valid <= 1'b0;
      bus.disp_data  <= 8'd0;
    end else begin
      unique case (state)
        IDLE: if (bus.io_load && bus.io_addr == 16'hFE06) begin
          state          <= SEND;
          bus.disp_valid <= 1'b1;
          bus.disp_data  <= bus.io_wdata[7:0];
        end
        SEND: if (bus.disp_ready) begin
          state          <= BUSY;
          bus.disp_valid <= 1'b0;
          dcnt           <= CW'(DISP_DELAY);
        end
        BUSY: begin
          dcnt <= dcnt - 1'b1;
          if (dcnt == CW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lc3_mmio_ctrl.sv
// tb_lc3_mmio_ctrl: directed and randomized checks of lc3_mmio_ctrl against a queue-based reference model
module tb_lc3_mmio_ctrl;
  localparam int DEPTH = 4;
  localparam int DLY   = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  lc3_mmio_ctrl_if bus();
  lc3_mmio_ctrl #(.KBD_DEPTH(DEPTH), .DISP_DELAY(DLY)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  int ecnt = 0;
  int idle_edge = 0;
  logic [7:0]  q[$];
  logic        kie = 1'b0, die = 1'b0, run = 1'b1, m_send = 1'b0, m_irq = 1'b0;
  logic [7:0]  dchar = 8'd0, m_intv = 8'd0;
  logic [2:0]  m_intp = 3'd0;
  logic [15:0] addrs [6] = '{16'hFE00, 16'hFE02, 16'hFE04, 16'hFE06, 16'hFFFE, 16'h3000};
  function automatic logic m_idle();
    return !m_send && ecnt >= idle_edge;
  endfunction
  function automatic logic [15:0] model_rd(logic [15:0] a);
    if (a == 16'hFE00) return {q.size() != 0, kie, 14'b0};
    if (a == 16'hFE02) return q.size() != 0 ? {8'h00, q[0]} : 16'h0000;
    if (a == 16'hFE04) return {m_idle(), die, 14'b0};
    if (a == 16'hFFFE) return {run, 15'b0};
    return 16'h0000;
  endfunction
  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    logic kreq, dreq, push, pop, dw, hs;
    if (rst) begin
      q.delete();
      kie = 1'b0; die = 1'b0; run = 1'b1; m_send = 1'b0; dchar = 8'd0;
      m_irq = 1'b0; m_intp = 3'd0; m_intv = 8'd0; idle_edge = 0;
    end else begin
      kreq = q.size() != 0 && kie;
      dreq = m_idle() && die;
      push = bus.kbd_valid && q.size() < DEPTH;
      pop  = bus.io_rd && bus.io_addr == 16'hFE02 && q.size() != 0;
      dw   = bus.io_load && bus.io_addr == 16'hFE06 && m_idle();
      hs   = m_send && bus.disp_ready;
      m_irq  = kreq || dreq;
      m_intp = kreq ? 3'd4 : dreq ? 3'd4 : 3'd0;
      m_intv = kreq ? 8'h80 : dreq ? 8'h81 : 8'h00;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(bus.kbd_data);
      if (bus.io_load && bus.io_addr == 16'hFE00) kie = bus.io_wdata[14];
      if (bus.io_load && bus.io_addr == 16'hFE04) die = bus.io_wdata[14];
      if (bus.io_load && bus.io_addr == 16'hFFFE) run = bus.io_wdata[15];
      if (dw) begin m_send = 1'b1; dchar = bus.io_wdata[7:0]; end
      if (hs) begin m_send = 1'b0; idle_edge = ecnt + 1 + DLY; end
    end
    @(posedge clk);
    ecnt++;
    #1;
    bus.io_load = 1'b0; bus.io_rd = 1'b0; bus.kbd_valid = 1'b0;
    chk("kbd_ready", bus.kbd_ready, q.size() < DEPTH);
    chk("disp_valid", bus.disp_valid, m_send);
    chk("disp_data", bus.disp_data, dchar);
    chk("IRQ", bus.IRQ, m_irq);
    chk("INTP", bus.INTP, m_intp);
    chk("INTV", bus.INTV, m_intv);
    chk("mcr_run", bus.mcr_run, run);
  endtask
  task automatic peek(logic [15:0] a, logic [15:0] exp);
    bus.io_addr = a;
    #1;
    chk($sformatf("rd_%h", a), bus.io_rdata, exp);
  endtask
  task automatic rdk(logic [15:0] exp);
    bus.io_addr = 16'hFE02;
    bus.io_rd = 1'b1;
    #1;
    chk("kbdr", bus.io_rdata, exp);
    tick();
  endtask
  task automatic wr(logic [15:0] a, logic [15:0] d);
    bus.io_addr = a; bus.io_wdata = d; bus.io_load = 1'b1;
    tick();
  endtask
  task automatic push(logic [7:0] c);
    bus.kbd_valid = 1'b1; bus.kbd_data = c;
    tick();
  endtask
  initial begin
    logic [15:0] a;
    int r;
    bus.io_addr = 16'h0; bus.io_wdata = 16'h0; bus.io_load = 1'b0; bus.io_rd = 1'b0;
    bus.kbd_valid = 1'b0; bus.kbd_data = 8'h0; bus.disp_ready = 1'b0;
    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    peek(16'hFE00, 16'h0000); peek(16'hFE04, 16'h8000); peek(16'hFFFE, 16'h8000);
    chk("rst_kbd_ready", bus.kbd_ready, 1'b1); chk("rst_irq", bus.IRQ, 1'b0);
    push(8'h41); push(8'h42);
    peek(16'hFE00, 16'h8000);
    rdk(16'h0041); rdk(16'h0042);
    peek(16'hFE00, 16'h0000);
    rdk(16'h0000);
    peek(16'hFE00, 16'h0000);
    for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i));
    chk("full_ready", bus.kbd_ready, 1'b0);
    push(8'h99);
    rdk(16'h0010);
    bus.io_addr = 16'hFE02; bus.io_rd = 1'b1; bus.kbd_valid = 1'b1; bus.kbd_data = 8'h55;
    #1;
    chk("kbdr_pushpop", bus.io_rdata, 16'h0011);
    tick();
    rdk(16'h0012); rdk(16'h0013); rdk(16'h0055);
    peek(16'hFE00, 16'h0000);
    wr(16'hFE06, 16'h0048);
    peek(16'hFE04, 16'h0000);
    chk("send_valid", bus.disp_valid, 1'b1); chk("send_data", bus.disp_data, 16'h0048);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_data", bus.disp_data, 16'h0048);
    end
    wr(16'hFE06, 16'h0077);
    chk("send_drop", bus.disp_data, 16'h0048);
    bus.disp_ready = 1'b1; tick(); bus.disp_ready = 1'b0;
    for (int j = 0; j < DLY; j++) begin
      peek(16'hFE04, 16'h0000);
      if (j == 2) wr(16'hFE06, 16'h005A); else tick();
    end
    peek(16'hFE04, 16'h8000);
    chk("busy_drop", bus.disp_data, 16'h0048); chk("idle_valid", bus.disp_valid, 1'b0);
    push(8'h5A);
    wr(16'hFE00, 16'h4000); wr(16'hFE04, 16'h4000);
    chk("irq_k", bus.IRQ, 1'b1); chk("intp_k", bus.INTP, 16'h4); chk("intv_k", bus.INTV, 16'h80);
    rdk(16'h005A);
    chk("intv_k2", bus.INTV, 16'h80);
    tick();
    chk("irq_d", bus.IRQ, 1'b1); chk("intv_d", bus.INTV, 16'h81);
    wr(16'hFE04, 16'h0000);
    chk("irq_hold", bus.IRQ, 1'b1);
    tick();
    chk("irq_clr", bus.IRQ, 1'b0);
    wr(16'hFE00, 16'h0000);
    wr(16'hFFFE, 16'h0000);
    chk("mcr_off", bus.mcr_run, 1'b0); peek(16'hFFFE, 16'h0000);
    wr(16'hFFFE, 16'h8000);
    peek(16'hFFFE, 16'h8000); peek(16'hFE06, 16'h0000); peek(16'h1234, 16'h0000);
    push(8'h01); push(8'h02);
    wr(16'hFE06, 16'h0033);
    chk("pre_rst_valid", bus.disp_valid, 1'b1);
    wr(16'hFFFE, 16'h0000);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_valid", bus.disp_valid, 1'b0);
    peek(16'hFE00, 16'h0000); peek(16'hFE04, 16'h8000);
    chk("rst_run", bus.mcr_run, 1'b1); chk("rst_ready", bus.kbd_ready, 1'b1);
    for (int n = 0; n < 600; n++) begin
      a = addrs[$urandom_range(0, 5)];
      r = int'($urandom_range(0, 7));
      bus.kbd_valid = $urandom_range(0, 1) == 1;
      bus.kbd_data = 8'($urandom);
      bus.disp_ready = $urandom_range(0, 3) == 0;
      bus.io_addr = a;
      bus.io_wdata = 16'($urandom);
      bus.io_rd = r < 3;
      bus.io_load = r == 3 || r == 4;
      rst = $urandom_range(0, 99) == 0;
      #1;
      chk("rand_rd", bus.io_rdata, model_rd(a));
      tick();
      rst = 1'b0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
